// File: rtl/hex_scan_display.sv
// Eight-digit multiplexed hex display driver for a 32-bit PIO word.
// The word is shadowed at frame boundaries so a digit never tears mid-frame.
module hex_scan_display #(
   parameter int PRESCALE = 50000,
   parameter int BLANK    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] data_in,
   input  logic [7:0]  dp_in,
   input  logic        enable,
   input  logic        blank_lz,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic [7:0]  dig_n,
   output logic        frame_done
);

   localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST_C  = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

   typedef enum logic [1:0] {IDLE, LOAD, SCAN} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    idx, idx_nxt;
   logic [31:0]   shadow, shadow_nxt;
   logic [7:0]    dp_shadow, dp_shadow_nxt;
   logic [6:0]    seg_nxt;
   logic [7:0]    dig_nxt;
   logic          dp_nxt;
   logic          fd_nxt;
   logic [7:0]    lz;
   logic          tick;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         default: hex7 = 7'h0E;
      endcase
   endfunction

   // lz[i]: nibbles i..7 of the shadow are all zero; digit 0 is always shown
   always_comb begin
      lz = '0;
      for (int i = 1; i < 8; i++) begin
         lz[i] = ((shadow >> (4 * i)) == 32'd0);
      end
   end

   assign tick = (cnt == LAST_C);

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      idx_nxt       = idx;
      shadow_nxt    = shadow;
      dp_shadow_nxt = dp_shadow;
      seg_nxt       = 7'h7F;
      dig_nxt       = 8'hFF;
      dp_nxt        = 1'b1;
      fd_nxt        = 1'b0;
      if (!enable) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         idx_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = LOAD;
               cnt_nxt   = '0;
               idx_nxt   = '0;
            end
            LOAD: begin
               shadow_nxt    = data_in;
               dp_shadow_nxt = dp_in;
               cnt_nxt       = '0;
               idx_nxt       = '0;
               state_nxt     = SCAN;
            end
            SCAN: begin
               if (!(cnt < BLANK_C) && !(blank_lz && lz[idx])) begin
                  dig_nxt = ~(8'd1 << idx);
                  seg_nxt = hex7(shadow[{idx, 2'b00} +: 4]);
                  dp_nxt  = ~dp_shadow[idx];
               end
               if (tick) begin
                  cnt_nxt = '0;
                  idx_nxt = idx + 3'd1;
                  if (idx == 3'd7) begin
                     shadow_nxt    = data_in;
                     dp_shadow_nxt = dp_in;
                     fd_nxt        = 1'b1;
                  end
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         shadow     <= '0;
         dp_shadow  <= '0;
         seg_n      <= 7'h7F;
         dig_n      <= 8'hFF;
         dp_n       <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         idx        <= idx_nxt;
         shadow     <= shadow_nxt;
         dp_shadow  <= dp_shadow_nxt;
         seg_n      <= seg_nxt;
         dig_n      <= dig_nxt;
         dp_n       <= dp_nxt;
         frame_done <= fd_nxt;
      end
   end

endmodule

// File: tb/tb_hex_scan_display.sv
// Directed bench for hex_scan_display: a reference model pushes the expected
// registered outputs each cycle; they are popped and compared after the edge.
module tb_hex_scan_display;
   localparam int PRESCALE = 4;
   localparam int BLANK    = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] data_in = '0;
   logic [7:0]  dp_in = '0;
   logic        enable = 1'b1;
   logic        blank_lz = 1'b0;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [7:0]  dig_n;
   logic        frame_done;

   typedef struct packed {
      logic [6:0] seg;
      logic       dp;
      logic [7:0] dig;
      logic       fd;
   } exp_t;

   exp_t expq[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_fd = -1;
   int fd_count = 0;
   int lit_count = 0;
   int dp_count = 0;

   int          m_state = 0;
   int          m_cnt = 0;
   int          m_idx = 0;
   logic [31:0] m_sh = '0;
   logic [7:0]  m_dp = '0;

   hex_scan_display #(.PRESCALE(PRESCALE), .BLANK(BLANK)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in),
      .enable(enable), .blank_lz(blank_lz), .seg_n(seg_n), .dp_n(dp_n),
      .dig_n(dig_n), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input logic [3:0] v);
      logic [6:0] t [16];
      t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return t[v];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step();
      exp_t e;
      exp_t g;
      logic [3:0] nib;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
      e.dig = 8'hFF;
      e.fd  = 1'b0;
      if (!reset && enable && m_state == 2) begin
         nib = m_sh[4*m_idx +: 4];
         if (m_cnt >= BLANK && !(blank_lz && m_idx != 0 && (m_sh >> (4 * m_idx)) == 32'd0)) begin
            e.seg = seg_of(nib);
            e.dig = ~(8'd1 << m_idx);
            e.dp  = ~m_dp[m_idx];
         end
         if (m_cnt == PRESCALE - 1 && m_idx == 7) e.fd = 1'b1;
      end
      expq.push_back(e);
      if (reset || !enable) last_fd = -1;

      if (reset) begin
         m_state = 0; m_cnt = 0; m_idx = 0; m_sh = '0; m_dp = '0;
      end else if (!enable) begin
         m_state = 0; m_cnt = 0; m_idx = 0;
      end else if (m_state == 0) begin
         m_state = 1;
      end else if (m_state == 1) begin
         m_sh = data_in; m_dp = dp_in; m_cnt = 0; m_idx = 0; m_state = 2;
      end else if (m_cnt == PRESCALE - 1) begin
         m_cnt = 0;
         if (m_idx == 7) begin
            m_sh = data_in;
            m_dp = dp_in;
         end
         m_idx = (m_idx + 1) % 8;
      end else begin
         m_cnt++;
      end

      @(posedge clk);
      #1;
      cyc++;
      g = expq.pop_front();
      chk("seg_n", 32'(seg_n), 32'(g.seg));
      chk("dig_n", 32'(dig_n), 32'(g.dig));
      chk("dp_n", 32'(dp_n), 32'(g.dp));
      chk("frame_done", 32'(frame_done), 32'(g.fd));
      if (dig_n !== 8'hFF) lit_count++;
      if (dp_n === 1'b0) dp_count++;
      if (frame_done === 1'b1) begin
         if (last_fd >= 0) chk("fd_period", 32'(cyc - last_fd), 32'd32);
         last_fd = cyc;
         fd_count++;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int guard;
      int first;
      int fd0;
      logic [6:0] s;

      // 1: reset, then first frame of 12345678
      data_in = 32'h12345678;
      reset = 1'b1;
      run(3);
      chk("rst_dig", 32'(dig_n), 32'hFF);
      chk("rst_seg", 32'(seg_n), 32'h7F);
      reset = 1'b0;
      first = 0;
      s = 7'h7F;
      for (int k = 1; k <= 6; k++) begin
         step();
         if (first == 0 && dig_n === 8'hFE) begin
            first = k;
            s = seg_n;
         end
      end
      chk("t1_first_lit", 32'(first), 32'd4);
      chk("t1_d0_seg", 32'(s), 32'h00);
      guard = 0;
      while (dig_n !== 8'h7F && guard < 40) begin step(); guard++; end
      chk("t1_d7_seg", 32'(seg_n), 32'h79);

      // 2: mid-frame change must wait for the wrap
      guard = 0;
      while (m_idx != 3 && guard < 40) begin step(); guard++; end
      chk("t2_reach_idx3", 32'(m_idx), 32'd3);
      data_in = 32'hDEADBEEF;
      guard = 0;
      while (frame_done !== 1'b1 && guard < 40) begin step(); guard++; end
      chk("t2_fd_seen", 32'(frame_done), 32'd1);
      guard = 0;
      while (dig_n !== 8'hFE && guard < 40) begin step(); guard++; end
      chk("t2_d0_seg", 32'(seg_n), 32'h0E);
      fd0 = fd_count;
      run(64);
      chk("t2_fd_count", 32'(fd_count - fd0), 32'd2);

      // 3: leading-zero blanking on and off
      data_in = 32'h000000A0;
      blank_lz = 1'b1;
      run(40);
      lit_count = 0;
      run(32);
      chk("t3_lit_lz1", 32'(lit_count), 32'd6);
      blank_lz = 1'b0;
      run(40);
      lit_count = 0;
      run(32);
      chk("t3_lit_lz0", 32'(lit_count), 32'd24);

      // 4: all zero, only digit 0 lit with its decimal point
      data_in = 32'h0;
      dp_in = 8'h01;
      blank_lz = 1'b1;
      run(40);
      lit_count = 0;
      dp_count = 0;
      run(32);
      chk("t4_lit", 32'(lit_count), 32'd3);
      chk("t4_dp", 32'(dp_count), 32'd3);

      // 5: enable drop mid-frame, restart via LOAD
      blank_lz = 1'b0;
      dp_in = 8'h00;
      data_in = 32'h89ABCDEF;
      run(40);
      guard = 0;
      while (!(m_state == 2 && m_idx == 5) && guard < 40) begin step(); guard++; end
      chk("t5_reach_idx5", 32'(m_idx), 32'd5);
      enable = 1'b0;
      fd0 = fd_count;
      step();
      chk("t5_dark", 32'(dig_n), 32'hFF);
      data_in = 32'hCAFE0123;
      run(3);
      chk("t5_no_fd", 32'(fd_count - fd0), 32'd0);
      enable = 1'b1;
      first = 0;
      s = 7'h7F;
      for (int k = 1; k <= 6; k++) begin
         step();
         if (first == 0 && dig_n === 8'hFE) begin
            first = k;
            s = seg_n;
         end
      end
      chk("t5_first_lit", 32'(first), 32'd4);
      chk("t5_d0_seg", 32'(s), 32'h30);

      // 6: reset on the wrap-tick cycle
      guard = 0;
      while (!(m_state == 2 && m_idx == 7 && m_cnt == PRESCALE - 1) && guard < 40) begin
         step();
         guard++;
      end
      chk("t6_reach_wrap", 32'(m_cnt), 32'(PRESCALE - 1));
      reset = 1'b1;
      fd0 = fd_count;
      step();
      chk("t6_no_fd", 32'(fd_count - fd0), 32'd0);
      chk("t6_dark", 32'(dig_n), 32'hFF);
      reset = 1'b0;
      run(12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
